mdio_master: RTL

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_master.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mdio_master.sv
// MDIO (clause 22) management master: shifts a latched 32-bit frame out on MDC/MDIO and captures read data.
// Optional 32-period preamble is built when the macro MDIO_PREAMBLE_EN is defined.
module mdio_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME, DONE} state_t;

    state_t      state, state_next;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_nxt;
    logic [31:0] frame;
    logic        is_read;
    logic [15:0] shift;
    logic        half_end;
    logic        period_end;
    logic        last_period;

    assign BUSY    = (state != IDLE);
    assign bit_nxt = bit_cnt + 5'd1;

    always_comb begin
        half_end    = (div_cnt == 8'(CLK_DIV - 1));
        period_end  = half_end && MDC;
        last_period = period_end && (bit_cnt == 5'd31);
        state_next  = state;
        case (state)
            IDLE: begin
                if (MDIO_START) begin
`ifdef MDIO_PREAMBLE_EN
                    state_next = PREAMBLE;
`else
                    state_next = FRAME;
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            PREAMBLE: if (last_period) state_next = FRAME;
`endif
            FRAME:    if (last_period) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MDC      <= 1'b0;
            MDIO_OUT <= 1'b0;
            MDIO_OE  <= 1'b0;
            RD_DATA  <= 16'h0000;
            DATA_RDY <= 1'b0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 5'd0;
            frame    <= 32'd0;
            is_read  <= 1'b0;
            shift    <= 16'd0;
        end else begin
            DATA_RDY <= 1'b0;
            case (state)
                IDLE: begin
                    MDC      <= 1'b0;
                    div_cnt  <= 8'd0;
                    bit_cnt  <= 5'd0;
                    MDIO_OUT <= 1'b0;
                    MDIO_OE  <= 1'b0;
                    if (MDIO_START) begin
                        frame   <= T_DATA;
                        is_read <= (T_DATA[29:28] == 2'b10);
                        MDIO_OE <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
                        MDIO_OUT <= 1'b1;
`else
                        MDIO_OUT <= T_DATA[31];
`endif
                    end
                end
                DONE: begin
                    MDC      <= 1'b0;
                    MDIO_OUT <= 1'b0;
                    MDIO_OE  <= 1'b0;
                end
                default: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        MDC     <= ~MDC;
                        if (!MDC) begin
                            // MDC about to rise: sample the PHY's read data bits
                            if (state == FRAME && is_read && bit_cnt[4])
                                shift <= {shift[14:0], MDIO_IN};
                        end else begin
                            bit_cnt <= bit_nxt;
                            if (state == FRAME && bit_cnt == 5'd31) begin
                                MDIO_OUT <= 1'b0;
                                MDIO_OE  <= 1'b0;
                                DATA_RDY <= 1'b1;
                                if (is_read) RD_DATA <= shift;
                            end else if (state == FRAME && is_read && bit_nxt >= 5'd14) begin
                                MDIO_OUT <= 1'b0;
                                MDIO_OE  <= 1'b0;
`ifdef MDIO_PREAMBLE_EN
                            end else if (state == PREAMBLE && bit_cnt != 5'd31) begin
                                MDIO_OUT <= 1'b1;
                                MDIO_OE  <= 1'b1;
`endif
                            end else begin
                                // wraps to bit 0 when leaving the preamble
                                MDIO_OUT <= frame[5'd31 - bit_nxt];
                                MDIO_OE  <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
